fpro_multi_bridge: RTL and testbench
====================================

# fpro_multi_bridge

Parametrised successor to the single-region FPro bridge: converts the MicroBlaze MCS IO bus into an FPro-style bus with `NUM_REGIONS` independently decoded chip-select regions. Slaves may stretch accesses with a per-region ready. An optional timeout watchdog reports bus errors. The block sits between the `microblaze_cpu` IO port and the MMIO/video subsystems in the top-level wrapper.

## Interface
- `BRG_BASE`, 32'hC000_0000, bridge base address; only bits above the region-select field are compared.
- `NUM_REGIONS`, 4, number of slave regions (2..8).
- `REGION_ADDR_BITS`, 21, word-address width per region.
  - Constraint: `REGION_ADDR_BITS + 2 + $clog2(NUM_REGIONS) <= 30`.
- `TIMEOUT_CYCLES`, 255, maximum cycles from the access cycle to slave ready (2..65535).
- `ERR_CNT_WIDTH`, 8, width of the saturating error counter.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `io_addr_strobe` in 1: MCS transaction strobe.
- `io_read_strobe` in 1: MCS read strobe.
- `io_write_strobe` in 1: MCS write strobe.
- `io_byte_enable` in 4: MCS byte enables.
- `io_address` in 32: MCS byte address.
- `io_write_data` in 32: MCS write data.
- `io_read_data` out 32: read data returned to the MCS.
- `io_ready` out 1: one-cycle completion pulse.
- `fp_cs` out NUM_REGIONS: one-hot region select.
- `fp_rd` out 1: read command.
- `fp_wr` out 1: write command.
- `fp_addr` out REGION_ADDR_BITS: word address within the region.
- `fp_wr_data` out 32: write data.
- `fp_be` out 4: byte enables.
- `fp_rd_data` in 32*NUM_REGIONS: packed read data; region k occupies `[32k+31:32k]`.
- `fp_ready` in NUM_REGIONS: per-region slave ready.
- `bus_err` out 1: one-cycle error pulse.
- `err_count` out ERR_CNT_WIDTH: saturating error count.

## Operation
Address fields:
- Region select: `RS = io_address[REGION_ADDR_BITS+2 +: $clog2(NUM_REGIONS)]`.
- Word address: `io_address[REGION_ADDR_BITS+1:2]`.
- Hit: `io_address` bits above RS equal the same bits of `BRG_BASE`, and `RS < NUM_REGIONS`.

FSM states are IDLE, ACCESS and WAIT.

IDLE:
- Acts when `io_addr_strobe & (io_read_strobe | io_write_strobe)`.
- If both read and write strobes are high, the access is a write.
- On a hit: latch region, address, data, byte enables and direction, then go to ACCESS.
- On a miss: stay in IDLE and, next cycle, pulse `io_ready`. `io_read_data` = 32'hDEAD_BEEF, pulse `bus_err`, and increment `err_count`. No `fp_cs` is asserted.

ACCESS (exactly one cycle):
- Drive `fp_cs[region]=1`, `fp_rd` or `fp_wr`, and `fp_addr`/`fp_wr_data`/`fp_be` from the latched values.
- Sample `fp_ready[region]`: high completes the access, low goes to WAIT.

WAIT:
- `fp_cs`, `fp_rd` and `fp_wr` are 0; `fp_addr`, `fp_wr_data` and `fp_be` hold their values.
- Sample `fp_ready[region]` every cycle. Readies of other regions are ignored.

Completion (registered):
- `io_ready` = 1 for one cycle, then the FSM returns to IDLE.
- Read: `io_read_data` = `fp_rd_data` slice of the region, captured on the ready edge.
- Write: `io_read_data` = 0.
- `io_read_data` holds between transactions.

Other rules:
- Strobes arriving while not in IDLE are ignored.
- `err_count` saturates at all-ones.

## Timing
- All outputs reset to 0 asynchronously. The FSM resets to IDLE and the timeout timer clears.
- Reset mid-transaction aborts the transaction with no `io_ready`.
- Zero-wait slave (`fp_ready` high in ACCESS): strobe sampled at edge 0, ACCESS in cycle 1, `io_ready` in cycle 2.
- N wait cycles: `io_ready` in cycle 2+N.
- Decode miss: `io_ready` and `bus_err` in cycle 1.
- Timeout (macro enabled):
  - The timer clears on entry to ACCESS and counts each cycle `fp_ready` is low.
  - Low for `TIMEOUT_CYCLES` consecutive cycles: error completion in cycle `TIMEOUT_CYCLES+1`. `io_read_data` = 32'hDEAD_BEEF, `bus_err` pulses, `err_count` increments.
  - `fp_ready` rising in the same cycle as expiry counts as a normal completion.

## Configuration
- `FPRO_BRIDGE_TIMEOUT_EN` defined: the timeout timer and timeout error path are compiled in.
- `FPRO_BRIDGE_TIMEOUT_EN` undefined:
  - No timer logic; WAIT waits indefinitely for `fp_ready`.
  - Decode-miss errors still drive `bus_err` and `err_count`.

## Test plan
- Write `io_address`=0xC080_0014, data 0x1234_5678, be 0xF, all `fp_ready` tied high -> cycle 1: `fp_cs`=4'b0010, `fp_wr`=1, `fp_addr`=5, `fp_wr_data`=0x1234_5678. Cycle 2: `io_ready`=1, `bus_err`=0.
- Read 0xC180_0008; region 3 raises `fp_ready` after 3 wait cycles with data 0xA5A5_0001 -> `fp_cs`=4'b1000 for one cycle, `fp_addr`=2. `io_ready` in cycle 5 with `io_read_data`=0xA5A5_0001.
- Read 0x8000_0000 -> no `fp_cs`. Cycle 1: `io_ready`=1, `io_read_data`=0xDEAD_BEEF, `bus_err` pulse, `err_count`=1.
- `TIMEOUT_CYCLES`=16, macro defined, region 0 `fp_ready` held low -> `io_ready` in cycle 17 with 0xDEAD_BEEF, `bus_err` pulse. Macro undefined: no `io_ready` within 1000 cycles.
- `ERR_CNT_WIDTH`=2, five decode misses -> `err_count` sequence 1,2,3,3,3.
- Drive `reset_n` low during WAIT -> all outputs 0 immediately, no `io_ready`. After release, a zero-wait write completes in cycle 2.

Source files
------------

// File: rtl/fpro_multi_bridge.sv
// MicroBlaze MCS IO bus to multi-region FPro bus bridge with per-region slave ready.
// Define FPRO_BRIDGE_TIMEOUT_EN to compile in the slave-ready timeout watchdog.
module fpro_multi_bridge #(
    parameter logic [31:0] BRG_BASE         = 32'hC000_0000,
    parameter int          NUM_REGIONS      = 4,
    parameter int          REGION_ADDR_BITS = 21,
    parameter int          TIMEOUT_CYCLES   = 255,
    parameter int          ERR_CNT_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          io_addr_strobe,
    input  logic                          io_read_strobe,
    input  logic                          io_write_strobe,
    input  logic [3:0]                    io_byte_enable,
    input  logic [31:0]                   io_address,
    input  logic [31:0]                   io_write_data,
    output logic [31:0]                   io_read_data,
    output logic                          io_ready,
    output logic [NUM_REGIONS-1:0]        fp_cs,
    output logic                          fp_rd,
    output logic                          fp_wr,
    output logic [REGION_ADDR_BITS-1:0]   fp_addr,
    output logic [31:0]                   fp_wr_data,
    output logic [3:0]                    fp_be,
    input  logic [32*NUM_REGIONS-1:0]     fp_rd_data,
    input  logic [NUM_REGIONS-1:0]        fp_ready,
    output logic                          bus_err,
    output logic [ERR_CNT_WIDTH-1:0]      err_count
);
    localparam int RS_BITS = $clog2(NUM_REGIONS);
    localparam int RS_LSB  = REGION_ADDR_BITS + 2;
    localparam int TAG_LSB = RS_LSB + RS_BITS;
    localparam logic [RS_BITS:0] REGION_LIMIT = (RS_BITS + 1)'(NUM_REGIONS);
    localparam logic [31:0]      ERR_DATA     = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;

    state_t             state;
    logic [RS_BITS-1:0] region;
    logic               is_wr;

    logic [RS_BITS-1:0] req_rs;
    logic               req_go;
    logic               req_hit;
    logic               sel_ready;
    logic [31:0]        sel_data;
    logic               timeout;
    logic               unused_addr_bits;

    assign req_rs  = io_address[RS_LSB +: RS_BITS];
    assign req_go  = io_addr_strobe & (io_read_strobe | io_write_strobe);
    assign req_hit = (io_address[31:TAG_LSB] == BRG_BASE[31:TAG_LSB]) &&
                     ({1'b0, req_rs} < REGION_LIMIT);
    assign unused_addr_bits = ^io_address[1:0];

    // Only the latched region's ready and read data are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (region == RS_BITS'(k)) begin
                sel_ready = fp_ready[k];
                sel_data  = fp_rd_data[32*k +: 32];
            end
        end
    end

`ifdef FPRO_BRIDGE_TIMEOUT_EN
    localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_BITS-1:0] timer;

    // Counts low-ready samples since the access began; IDLE clears it for the next entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timer <= '0;
        else if (state == IDLE)
            timer <= '0;
        else if (!sel_ready)
            timer <= timer + TMR_BITS'(1);
    end

    assign timeout = !sel_ready && (timer == TMR_BITS'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            region       <= '0;
            is_wr        <= 1'b0;
            io_read_data <= '0;
            io_ready     <= 1'b0;
            fp_cs        <= '0;
            fp_rd        <= 1'b0;
            fp_wr        <= 1'b0;
            fp_addr      <= '0;
            fp_wr_data   <= '0;
            fp_be        <= '0;
            bus_err      <= 1'b0;
            err_count    <= '0;
        end else begin
            io_ready <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_go && req_hit) begin
                        region     <= req_rs;
                        is_wr      <= io_write_strobe;
                        fp_cs      <= NUM_REGIONS'(1) << req_rs;
                        fp_rd      <= ~io_write_strobe;
                        fp_wr      <= io_write_strobe;
                        fp_addr    <= io_address[REGION_ADDR_BITS+1:2];
                        fp_wr_data <= io_write_data;
                        fp_be      <= io_byte_enable;
                        state      <= ACCESS;
                    end else if (req_go) begin
                        io_ready     <= 1'b1;
                        bus_err      <= 1'b1;
                        io_read_data <= ERR_DATA;
                        if (err_count != '1)
                            err_count <= err_count + ERR_CNT_WIDTH'(1);
                    end
                end
                ACCESS, WAIT: begin
                    fp_cs <= '0;
                    fp_rd <= 1'b0;
                    fp_wr <= 1'b0;
                    // A ready arriving on the expiry sample wins over the timeout.
                    if (sel_ready) begin
                        io_ready     <= 1'b1;
                        io_read_data <= is_wr ? 32'd0 : sel_data;
                        state        <= IDLE;
                    end else if (timeout) begin
                        io_ready     <= 1'b1;
                        bus_err      <= 1'b1;
                        io_read_data <= ERR_DATA;
                        if (err_count != '1)
                            err_count <= err_count + ERR_CNT_WIDTH'(1);
                        state        <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpro_multi_bridge.sv
// Randomized bench for fpro_multi_bridge: bus-level slave driver plus a decode/latency reference model.
module tb_fpro_multi_bridge;
    localparam int          N    = 4;
    localparam int          RAB  = 21;
    localparam int          TMO  = 16;
    localparam int          ECW  = 2;
    localparam int          RSB  = $clog2(N);
    localparam logic [31:0] BASE = 32'hC000_0000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              io_addr_strobe = 1'b0;
    logic              io_read_strobe = 1'b0;
    logic              io_write_strobe = 1'b0;
    logic [3:0]        io_byte_enable = '0;
    logic [31:0]       io_address = '0;
    logic [31:0]       io_write_data = '0;
    logic [31:0]       io_read_data;
    logic              io_ready;
    logic [N-1:0]      fp_cs;
    logic              fp_rd;
    logic              fp_wr;
    logic [RAB-1:0]    fp_addr;
    logic [31:0]       fp_wr_data;
    logic [3:0]        fp_be;
    logic [32*N-1:0]   fp_rd_data = '0;
    logic [N-1:0]      fp_ready = '0;
    logic              bus_err;
    logic [ECW-1:0]    err_count;

    int                checks = 0;
    int                failures = 0;
    logic [31:0]       exp_q[$];
    logic [ECW-1:0]    exp_err = '0;

    always #5 clk = ~clk;

    fpro_multi_bridge #(
        .BRG_BASE(BASE), .NUM_REGIONS(N), .REGION_ADDR_BITS(RAB),
        .TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(ECW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .fp_cs(fp_cs), .fp_rd(fp_rd), .fp_wr(fp_wr), .fp_addr(fp_addr),
        .fp_wr_data(fp_wr_data), .fp_be(fp_be), .fp_rd_data(fp_rd_data),
        .fp_ready(fp_ready), .bus_err(bus_err), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference decode: tag match on bits above the region field, region index in range.
    function automatic int model_rs(input logic [31:0] a);
        return int'((a >> (RAB + 2)) & ((32'd1 << RSB) - 1));
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return ((a >> (RAB + 2 + RSB)) == (BASE >> (RAB + 2 + RSB))) && (model_rs(a) < N);
    endfunction

    function automatic logic [31:0] model_waddr(input logic [31:0] a);
        return (a >> 2) & ((32'd1 << RAB) - 1);
    endfunction

    function automatic logic [ECW-1:0] err_inc(input logic [ECW-1:0] c);
        return (c == {ECW{1'b1}}) ? c : c + ECW'(1);
    endfunction

    task automatic randomize_slaves(input int keep_rs);
        for (int k = 0; k < N; k++) begin
            fp_rd_data[32*k +: 32] = $urandom;
            if (k != keep_rs) fp_ready[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic issue(input logic [31:0] addr, input int kind, input logic [31:0] wdata,
                         input logic [3:0] be);
        @(negedge clk);
        io_address      = addr;
        io_write_data   = wdata;
        io_byte_enable  = be;
        io_read_strobe  = (kind != 1);
        io_write_strobe = (kind != 0);
        io_addr_strobe  = 1'b1;
        @(posedge clk); #1;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_address      = $urandom;
        io_write_data   = $urandom;
        io_byte_enable  = 4'($urandom);
    endtask

    // kind: 0 read, 1 write, 2 both strobes (treated as write). rdata is what the slave returns.
    task automatic run_access(input logic [31:0] addr, input int kind, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] rdata, input int waits);
        logic        hit;
        logic        wr;
        int          rs;
        logic [31:0] want;
        hit = model_hit(addr);
        rs  = model_rs(addr);
        wr  = (kind != 0);
        randomize_slaves(hit ? rs : -1);
        if (hit) begin
            fp_ready[rs] = (waits == 0);
            if (waits == 0) begin
                fp_rd_data[32*rs +: 32] = rdata;
                exp_q.push_back(wr ? 32'd0 : rdata);
            end
        end
        issue(addr, kind, wdata, be);
        if (!hit) begin
            exp_err = err_inc(exp_err);
            check("miss_ready", 32'(io_ready), 32'd1);
            check("miss_bus_err", 32'(bus_err), 32'd1);
            check("miss_data", io_read_data, 32'hDEAD_BEEF);
            check("miss_cs", 32'(fp_cs), 32'd0);
            check("miss_err_count", 32'(err_count), 32'(exp_err));
            @(posedge clk); #1;
            check("miss_ready_pulse", 32'(io_ready), 32'd0);
            check("miss_err_pulse", 32'(bus_err), 32'd0);
            return;
        end
        check("acc_cs", 32'(fp_cs), 32'd1 << rs);
        check("acc_rd", 32'(fp_rd), 32'(!wr));
        check("acc_wr", 32'(fp_wr), 32'(wr));
        check("acc_addr", 32'(fp_addr), model_waddr(addr));
        check("acc_wdata", fp_wr_data, wdata);
        check("acc_be", 32'(fp_be), 32'(be));
        check("acc_no_ready", 32'(io_ready), 32'd0);
        for (int i = 1; i <= waits; i++) begin
            @(posedge clk); #1;
            check("wait_cs", 32'(fp_cs), 32'd0);
            check("wait_cmd", 32'({fp_rd, fp_wr}), 32'd0);
            check("wait_addr", 32'(fp_addr), model_waddr(addr));
            check("wait_wdata", fp_wr_data, wdata);
            check("wait_no_ready", 32'(io_ready), 32'd0);
            randomize_slaves(rs);
            fp_ready[rs] = (i == waits);
            if (i == waits) begin
                fp_rd_data[32*rs +: 32] = rdata;
                exp_q.push_back(wr ? 32'd0 : rdata);
            end
        end
        @(posedge clk); #1;
        fp_ready[rs] = 1'b0;
        fp_rd_data[32*rs +: 32] = $urandom;
        want = 32'hx;
        if (exp_q.size() == 0) check("sb_queue_empty", 32'd0, 32'd1);
        else want = exp_q.pop_front();
        check("done_ready", 32'(io_ready), 32'd1);
        check("done_bus_err", 32'(bus_err), 32'd0);
        check("done_data", io_read_data, want);
        @(posedge clk); #1;
        check("done_ready_pulse", 32'(io_ready), 32'd0);
        check("done_data_hold", io_read_data, want);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        exp_err = '0;
        exp_q.delete();
        fp_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic timeout_test();
        int seen;
        seen = 0;
        fp_ready = '0;
        issue(32'hC000_0040, 0, 32'd0, 4'hF);
`ifdef FPRO_BRIDGE_TIMEOUT_EN
        for (int c = 1; c <= TMO; c++) begin
            if (io_ready) seen++;
            @(posedge clk); #1;
        end
        check("tmo_early_ready", 32'(seen), 32'd0);
        exp_err = err_inc(exp_err);
        check("tmo_ready", 32'(io_ready), 32'd1);
        check("tmo_data", io_read_data, 32'hDEAD_BEEF);
        check("tmo_bus_err", 32'(bus_err), 32'd1);
        check("tmo_err_count", 32'(err_count), 32'(exp_err));
        @(posedge clk); #1;
        check("tmo_ready_pulse", 32'(io_ready), 32'd0);
`else
        repeat (1000) begin
            @(posedge clk); #1;
            if (io_ready) seen++;
        end
        check("no_tmo_ready", 32'(seen), 32'd0);
        apply_reset();
`endif
    endtask

    task automatic reset_in_wait_test();
        int seen;
        seen = 0;
        fp_ready = '0;
        issue(32'hC100_0100, 0, 32'h5555_AAAA, 4'h3);
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_io_ready", 32'(io_ready), 32'd0);
        check("rst_cs", 32'(fp_cs), 32'd0);
        check("rst_cmd", 32'({fp_rd, fp_wr}), 32'd0);
        check("rst_addr", 32'(fp_addr), 32'd0);
        check("rst_wdata", fp_wr_data, 32'd0);
        check("rst_be", 32'(fp_be), 32'd0);
        check("rst_rdata", io_read_data, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        fp_ready = '1;
        repeat (3) begin
            @(posedge clk); #1;
            if (io_ready) seen++;
        end
        exp_err = '0;
        exp_q.delete();
        fp_ready = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (io_ready) seen++;
        end
        check("rst_no_ready", 32'(seen), 32'd0);
        run_access(32'hC080_0014, 1, 32'h1234_5678, 4'hF, 32'd0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        apply_reset();
        @(posedge clk); #1;
        check("reset_ready", 32'(io_ready), 32'd0);
        check("reset_rdata", io_read_data, 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_cs", 32'(fp_cs), 32'd0);

        // Saturation sequence 1,2,3,3,3 on a 2-bit counter.
        run_access(32'h8000_0000, 0, 32'd0, 4'hF, 32'd0, 0);
        for (int i = 0; i < 4; i++)
            run_access(32'h0000_1000 + 32'(i * 4), $urandom_range(0, 2), $urandom, 4'hF, 32'd0, 0);

        run_access(32'hC080_0014, 1, 32'h1234_5678, 4'hF, 32'd0, 0);
        run_access(32'hC180_0008, 0, 32'h0, 4'hF, 32'hA5A5_0001, 3);
        run_access(32'hC100_0FFC, 2, 32'hCAFE_F00D, 4'h6, 32'h0, 1);
        run_access(32'hC000_0000, 0, 32'h0, 4'h1, 32'h0BAD_C0DE, TMO - 1);

        timeout_test();

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) != 0) a = {BASE[31:25], 25'($urandom)};
            else a = $urandom;
            run_access(a, $urandom_range(0, 2), $urandom, 4'($urandom), $urandom, $urandom_range(0, 6));
        end

        reset_in_wait_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
